imem_program_loader: RTL and testbench
======================================

Name: imem_program_loader

Overview:
- Writer side of the pipeline processor's instruction memory. The core only reads instruction memory during fetch; this block fills it.
- Accepts a byte stream over a valid/ready handshake, parses a framed program image, and writes each payload byte into instruction memory.
- Verifies a checksum and holds the processor in reset until a valid image has been loaded.

Parameters:
- DATA_W, 8, instruction/byte width.
- DEPTH, 16, instruction memory entries.
- ADDR_W, 4, instruction memory address width (clog2 DEPTH).
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  stream byte valid
- in_data  in  DATA_W  stream byte
- in_ready  out  1  loader can accept a byte
- imem_we  out  1  instruction memory write enable
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  DATA_W  write data
- cpu_hold  out  1  high keeps the processor (PC/pipeline) in reset
- load_done  out  1  one-cycle pulse when an image is accepted
- load_err  out  1  sticky error flag; cleared when the next SYNC_BYTE is accepted
- words_loaded  out  ADDR_W+1  length of the last good image

Behaviour:
- Handshake:
  - A byte transfers on a rising clk edge where in_valid && in_ready.
  - in_valid may drop or stall at any time without side effects.
  - in_ready is combinational from state: 1 in IDLE, LEN, DATA and CSUM; 0 in DONE and ERR.
- Frame format: SYNC_BYTE, LEN (1..DEPTH), LEN payload bytes, CSUM = sum of payload bytes mod 2^DATA_W.
- FSM states: IDLE, LEN, DATA, CSUM, DONE, ERR.
- IDLE:
  - Accepted bytes other than SYNC_BYTE are discarded.
  - On SYNC_BYTE: go to LEN, set cpu_hold=1, clear load_err, clear sum and address counter.
- LEN:
  - Accepted byte of 0 or >DEPTH: go to ERR.
  - Otherwise latch count, go to DATA.
- DATA:
  - Each accepted byte produces a registered write: imem_we=1 in the cycle after the handshake, with imem_addr = current address and imem_wdata = byte.
  - Address increments from 0, sum += byte (wraps mod 256).
  - After the LEN-th byte, go to CSUM.
- CSUM:
  - Accepted byte == sum: go to DONE.
  - Otherwise go to ERR.
- DONE (1 cycle): load_done=1, words_loaded=LEN, cpu_hold=0, then go to IDLE.
- ERR (1 cycle): load_err=1 (sticky), cpu_hold stays 1, then go to IDLE.
- Memory contents: a failed load leaves partially written memory. The processor stays held until a later image succeeds.
- A SYNC_BYTE value inside LEN, DATA or CSUM is treated as ordinary data; there is no resync mid-frame.
- Reset values: state IDLE, cpu_hold=1, imem_we=0, imem_addr=0, imem_wdata=0, load_done=0, load_err=0, words_loaded=0, internal sum/count=0.
- Reset mid-frame:
  - Aborts the frame immediately and suppresses any pending write.
  - Memory is not cleared.
- imem_we is never asserted outside DATA-driven writes. At most one write per cycle; address never exceeds DEPTH-1.
- Latency: last CSUM handshake edge -> load_done and cpu_hold=0 one cycle later.

Decomposition:
- Shared package pipe_pkg holds:
  - DATA_W, DEPTH, ADDR_W, SYNC_BYTE;
  - the loader state enum (IDLE, LEN, DATA, CSUM, DONE, ERR);
  - the processor opcode constants ADD=8'h01, SUB=8'h02, LOAD=8'h03, for use by benches building images.
- One natural sub-module, loader_checksum: a running mod-2^DATA_W accumulator with clear, add-enable and compare output. Everything else stays in imem_program_loader.

Test Plan:
- Good image: stream A5 03 01 02 03 06, in_valid held high -> writes addr0=01, addr1=02, addr2=03 on consecutive cycles; load_done pulses once; cpu_hold falls; words_loaded=3; load_err=0.
- Bad checksum: A5 02 01 02 07 -> two writes occur; load_err=1; cpu_hold stays 1; no load_done. Then A5 01 03 03 -> load_err clears at the sync byte, load_done pulses, cpu_hold=0.
- Illegal length:
  - A5 00 -> ERR, with no writes.
  - A5 11 -> ERR, with no writes.
  - Both cases: load_err=1, in_ready=0 for exactly one cycle.
- Leading garbage and stalls: 00 FF A5 01 A5 A5, with in_valid toggling every other cycle -> garbage ignored; single write addr0=A5; load_done pulses.
- Full depth: A5 10, then payload 00..0F, then 78 -> 16 writes at addr 0..15; imem_addr never wraps; words_loaded=16; load_done pulses.
- Reset mid-frame: assert reset after the 2nd payload byte of a 4-byte frame -> all outputs go to reset values in the same cycle; no further writes; a new full frame then loads normally.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants and types for the pipeline processor and its instruction-memory loader.
//   DATA_W    : instruction / stream byte width
//   DEPTH     : instruction memory entries
//   ADDR_W    : instruction memory address width
//   SYNC_BYTE : frame start marker for the program loader
//   ADD/SUB/LOAD : processor opcodes, used when building program images
//   loader_state_e : program loader FSM states
package pipe_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 4;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam logic [7:0] ADD  = 8'h01;
  localparam logic [7:0] SUB  = 8'h02;
  localparam logic [7:0] LOAD = 8'h03;

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StData,
    StCsum,
    StDone,
    StErr
  } loader_state_e;

endpackage

// File: rtl/loader_checksum.sv
// Running mod-2^DATA_W checksum accumulator for the program loader.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : zero the accumulator (wins over add_en)
//   add_en     : add add_data into the accumulator this cycle
//   add_data   : byte to accumulate
//   cmp_data   : value compared against the current sum
//   match      : current sum equals cmp_data (combinational)
module loader_checksum #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              add_en,
  input  logic [DATA_W-1:0] add_data,
  input  logic [DATA_W-1:0] cmp_data,
  output logic              match
);

  logic [DATA_W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clear) begin
      sum_d = '0;
    end else if (add_en) begin
      // Natural wrap of the DATA_W-bit add gives the modulo.
      sum_d = sum_q + add_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign match = (sum_q == cmp_data);

endmodule

// File: rtl/imem_program_loader.sv
// Instruction memory writer: parses a framed byte stream (SYNC, LEN, payload, CSUM)
// received over valid/ready, writes payload bytes into instruction memory and holds
// the processor in reset until an image with a correct checksum has been loaded.
//   clk, reset    : clock, asynchronous active-high reset
//   in_valid/in_data/in_ready : byte stream handshake
//   imem_we/imem_addr/imem_wdata : registered instruction memory write port
//   cpu_hold      : keeps the processor in reset while high
//   load_done     : one-cycle pulse when an image is accepted
//   load_err      : sticky error flag, cleared by the next accepted SYNC byte
//   words_loaded  : length of the last good image
module imem_program_loader #(
  parameter int unsigned        DATA_W    = pipe_pkg::DATA_W,
  parameter int unsigned        DEPTH     = pipe_pkg::DEPTH,
  parameter int unsigned        ADDR_W    = pipe_pkg::ADDR_W,
  parameter logic [DATA_W-1:0]  SYNC_BYTE = pipe_pkg::SYNC_BYTE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  import pipe_pkg::*;

  localparam logic [DATA_W-1:0] DepthVal = DATA_W'(DEPTH);

  loader_state_e state_q, state_d;

  logic              hold_q, hold_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;   // payload bytes taken so far == next write address
  logic [ADDR_W:0]   words_q, words_d;

  logic xfer;
  logic sum_clear, sum_add, sum_match;

  assign in_ready = (state_q == StIdle) || (state_q == StLen) ||
                    (state_q == StData) || (state_q == StCsum);
  assign xfer     = in_valid && in_ready;

  loader_checksum #(
    .DATA_W (DATA_W)
  ) u_checksum (
    .clk      (clk),
    .reset    (reset),
    .clear    (sum_clear),
    .add_en   (sum_add),
    .add_data (in_data),
    .cmp_data (in_data),
    .match    (sum_match)
  );

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    done_d    = 1'b0;
    err_d     = err_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    words_d   = words_q;
    sum_clear = 1'b0;
    sum_add   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (xfer && (in_data == SYNC_BYTE)) begin
          state_d   = StLen;
          hold_d    = 1'b1;
          err_d     = 1'b0;
          cnt_d     = '0;
          sum_clear = 1'b1;
        end
      end
      StLen: begin
        if (xfer) begin
          if ((in_data == '0) || (in_data > DepthVal)) begin
            state_d = StErr;
            err_d   = 1'b1;
          end else begin
            // Legal lengths fit in ADDR_W+1 bits, so the upper bits are zero here.
            len_d   = in_data[ADDR_W:0];
            state_d = StData;
          end
        end
      end
      StData: begin
        if (xfer) begin
          we_d    = 1'b1;
          addr_d  = cnt_q[ADDR_W-1:0];
          wdata_d = in_data;
          sum_add = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_d == len_q) begin
            state_d = StCsum;
          end
        end
      end
      StCsum: begin
        if (xfer) begin
          if (sum_match) begin
            state_d = StDone;
            done_d  = 1'b1;
            hold_d  = 1'b0;
            words_d = len_q;
          end else begin
            state_d = StErr;
            err_d   = 1'b1;
          end
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      hold_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      len_q   <= '0;
      cnt_q   <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      words_q <= words_d;
    end
  end

  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign cpu_hold     = hold_q;
  assign load_done    = done_q;
  assign load_err     = err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Scoreboard bench for imem_program_loader: stimulus pushes expected events
// (writes, done pulses, error cycles); a negedge monitor pops and compares.
module tb_imem_program_loader;
  import pipe_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;
  logic [ADDR_W:0]   words_loaded;

  imem_program_loader u_dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  localparam logic [1:0] EvWr   = 2'd0;
  localparam logic [1:0] EvDone = 2'd1;
  localparam logic [1:0] EvErr  = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] a;   // write address / done length
    logic [7:0] d;   // write data
  } ev_t;

  ev_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_wr(input int addr, input int data);
    ev_t e;
    e.kind = EvWr; e.a = 8'(addr); e.d = 8'(data);
    exp_q.push_back(e);
  endtask

  task automatic push_done(input int len);
    ev_t e;
    e.kind = EvDone; e.a = 8'(len); e.d = 8'h00;
    exp_q.push_back(e);
  endtask

  task automatic push_err();
    ev_t e;
    e.kind = EvErr; e.a = 8'h00; e.d = 8'h00;
    exp_q.push_back(e);
  endtask

  // Pop the next expected event and confirm the observed kind matches it.
  task automatic take(input string what, input logic [1:0] kind, output ev_t e, output bit ok);
    ok = 1'b0;
    e  = '0;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected %s: got event, expected none at %0t", what, $time);
    end else begin
      e = exp_q.pop_front();
      check({"event kind ", what}, 32'(kind), 32'(e.kind));
      ok = (e.kind == kind);
    end
  endtask

  ev_t mon_ev;
  bit  mon_ok;

  always @(negedge clk) begin
    if (!reset) begin
      if (imem_we) begin
        take("write", EvWr, mon_ev, mon_ok);
        if (mon_ok) begin
          check("write addr", 32'(imem_addr), 32'(mon_ev.a));
          check("write data", 32'(imem_wdata), 32'(mon_ev.d));
          check("hold during write", 32'(cpu_hold), 32'd1);
        end
      end
      if (load_done) begin
        take("done", EvDone, mon_ev, mon_ok);
        if (mon_ok) begin
          check("words_loaded", 32'(words_loaded), 32'(mon_ev.a));
          check("hold after done", 32'(cpu_hold), 32'd0);
          check("err at done", 32'(load_err), 32'd0);
        end
      end
      // Only the error state stalls the stream without a done pulse.
      if (!in_ready && !load_done) begin
        take("error", EvErr, mon_ev, mon_ok);
        if (mon_ok) begin
          check("load_err in err", 32'(load_err), 32'd1);
          check("hold in err", 32'(cpu_hold), 32'd1);
        end
      end
    end
  end

  // Present one byte, wait (bounded) for its handshake, then idle for gap cycles.
  task automatic send(input logic [7:0] b, input int gap);
    int  n;
    logic acc;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      n++;
    end while (!acc && n < 20);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL handshake timeout: got in_ready=0 expected 1 for byte %0h", b);
    end
    #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " imem_we"},      32'(imem_we), 32'd0);
    check({tag, " imem_addr"},    32'(imem_addr), 32'd0);
    check({tag, " imem_wdata"},   32'(imem_wdata), 32'd0);
    check({tag, " cpu_hold"},     32'(cpu_hold), 32'd1);
    check({tag, " load_done"},    32'(load_done), 32'd0);
    check({tag, " load_err"},     32'(load_err), 32'd0);
    check({tag, " words_loaded"}, 32'(words_loaded), 32'd0);
    check({tag, " in_ready"},     32'(in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout: simulation still running, expected to finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #1;
    check_reset_values("reset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(1);

    // Good three-byte image.
    push_wr(0, 8'h01); push_wr(1, 8'h02); push_wr(2, 8'h03); push_done(3);
    send(SYNC_BYTE, 0); send(8'h03, 0);
    send(ADD, 0); send(SUB, 0); send(LOAD, 0); send(8'h06, 0);
    idle(3);
    check("hold after good image", 32'(cpu_hold), 32'd0);

    // Bad checksum, then a good one-byte image clears the error.
    push_wr(0, 8'h01); push_wr(1, 8'h02); push_err();
    send(SYNC_BYTE, 0); send(8'h02, 0); send(8'h01, 0); send(8'h02, 0); send(8'h07, 0);
    idle(3);
    check("sticky err after bad csum", 32'(load_err), 32'd1);
    check("hold after bad csum", 32'(cpu_hold), 32'd1);
    check("words kept after bad csum", 32'(words_loaded), 32'd3);
    push_wr(0, 8'h03); push_done(1);
    send(SYNC_BYTE, 0);
    check("err cleared by sync", 32'(load_err), 32'd0);
    send(8'h01, 0); send(8'h03, 0); send(8'h03, 0);
    idle(3);

    // Illegal lengths: zero and DEPTH+1.
    push_err();
    send(SYNC_BYTE, 0); send(8'h00, 0);
    idle(2);
    check("err after len 0", 32'(load_err), 32'd1);
    push_err();
    send(SYNC_BYTE, 0); send(8'h11, 0);
    idle(2);
    check("err after len 17", 32'(load_err), 32'd1);
    check("hold after bad len", 32'(cpu_hold), 32'd1);

    // Leading garbage with a bubble after every byte; in-frame A5 is plain data.
    push_wr(0, 8'hA5); push_done(1);
    send(8'h00, 1); send(8'hFF, 1); send(SYNC_BYTE, 1);
    send(8'h01, 1); send(8'hA5, 1); send(8'hA5, 1);
    idle(3);

    // Full-depth image: payload 00..0F, checksum 0x78.
    for (int i = 0; i < 16; i++) push_wr(i, i);
    push_done(16);
    send(SYNC_BYTE, 0); send(8'h10, 0);
    for (int i = 0; i < 16; i++) send(8'(i), 0);
    send(8'h78, 0);
    idle(3);
    check("words after full depth", 32'(words_loaded), 32'd16);

    // Reset after the 2nd payload byte: its write is suppressed.
    push_wr(0, 8'h11);
    send(SYNC_BYTE, 0); send(8'h04, 0); send(8'h11, 0); send(8'h22, 0);
    reset = 1'b1;
    #1;
    check_reset_values("mid-frame reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);
    push_wr(0, 8'h11); push_wr(1, 8'h22); push_wr(2, 8'h33); push_wr(3, 8'h44); push_done(4);
    send(SYNC_BYTE, 0); send(8'h04, 0);
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0); send(8'hAA, 0);
    idle(5);

    check("pending expected events", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
